sig_packer: RTL
===============

# sig_packer

Receiving end of the 3-bit `some_sig` symbol link driven by the producer. It accepts one symbol per valid/ready handshake and packs `SYMS_PER_WORD` consecutive symbols into one wide word. It presents that word on a registered valid/ready output toward the downstream consumer. A `in_last` marker flushes a partial word early, and a wrapping counter records how many words have been delivered.

## Interface
Parameters:
- `SYM_W`, default 3: symbol width; matches `some_sig`.
- `SYMS_PER_WORD`, default 4: symbols per packed word; legal values 2..8.
- `CNT_W`, default 16: width of the delivered-word counter.

Ports:
- `clk`  input  1  — single clock; all logic on the rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `in_valid`  input  1  — symbol present.
- `in_ready`  output  1  — block accepts the symbol this cycle.
- `in_sig`  input  SYM_W  — symbol (the `some_sig` payload).
- `in_last`  input  1  — this symbol closes the current word, even if the word is partial.
- `out_valid`  output  1  — packed word present.
- `out_ready`  input  1  — downstream accepts the word.
- `out_data`  output  SYM_W*SYMS_PER_WORD  — packed word; first-received symbol in bits [SYM_W-1:0].
- `out_count`  output  $clog2(SYMS_PER_WORD+1)  — number of valid symbols in `out_data`, 1..SYMS_PER_WORD.
- `out_last`  output  1  — word was closed by `in_last`.
- `word_cnt`  output  CNT_W  — count of completed output handshakes; wraps.

## Operation
- Input handshake: a symbol is accepted when `in_valid && in_ready`.
- Output handshake: a word is consumed when `out_valid && out_ready`.
- Fill state:
  - `fill_cnt` runs 0..SYMS_PER_WORD-1.
  - An accepted symbol is written at slot `fill_cnt` of the accumulator.
- Completion: the accepted symbol completes the word when `fill_cnt == SYMS_PER_WORD-1` or `in_last` is set. On completion:
  - The accumulator, including the current symbol, moves to `out_data`.
  - Slots beyond the last filled slot are forced to 0.
  - `out_count` = `fill_cnt`+1.
  - `out_last` = `in_last`.
  - `out_valid` is set.
  - `fill_cnt` and the accumulator clear to 0.
- Non-completing accept: the symbol is stored and `fill_cnt` increments. The output register is unaffected.
- `in_ready` = !rst && (!out_valid || out_ready). This rule applies to every symbol, completing or not.
- State machine:
  - EMPTY (fill_cnt==0, !out_valid)
  - FILLING (fill_cnt>0, !out_valid)
  - HOLD (out_valid, !out_ready): input stalled, `out_*` held stable.
  - EMPTY/FILLING → HOLD on completion.
  - HOLD → EMPTY/FILLING on output handshake.
- Simultaneous output handshake and completing accept in the same cycle: `out_valid` stays 1 and the new word replaces the old one. No bubble, no loss.
- Output handshake without a new completion: `out_valid` clears to 0. `out_data`, `out_count` and `out_last` hold their last values.
- `word_cnt` increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
- `in_last` on the first symbol of a word produces `out_count`=1.
- `in_last` with `fill_cnt==SYMS_PER_WORD-1` produces a full word with `out_last`=1.
- Reset mid-word discards the partial accumulator and any held word.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_count`=0, `out_last`=0, `word_cnt`=0.
  - `fill_cnt`=0, accumulator=0.
  - `in_ready`=0 while `rst` is high, and 1 in the first cycle after release.
- Latency: a completing symbol accepted at edge N gives `out_valid`=1 with the word visible after edge N, i.e. 1 cycle.
- Throughput: one symbol per cycle sustained while `out_ready`=1, giving one word every SYMS_PER_WORD cycles.
- `in_ready` depends combinationally on `out_ready`. There is no path from `in_valid` to `in_ready`.
- Output stability: `out_data`, `out_count` and `out_last` do not change while `out_valid && !out_ready`.

## Test plan
- Reset, then stream symbols 1,2,3,4 with `out_ready`=1 → one cycle after the 4th accept: `out_data`=12'h8D1 (4,3,2,1 packed LSB-first), `out_count`=4, `out_last`=0; `word_cnt`=1 after the handshake.
- Symbols 5,6 with `in_last` on the 6 → `out_data`=12'h035, `out_count`=2, `out_last`=1.
- Complete a word with `out_ready`=0 for 5 cycles → `in_ready`=0 and `out_*` stable throughout; raising `out_ready` with `in_valid` high gives back-to-back accept, and the next word follows 4 cycles later.
- Continuous 1000-symbol random stream with `out_ready`=1 → 250 words, no gaps in `in_ready`, `word_cnt`=250, payloads match the scoreboard.
- Preload `word_cnt` to 16'hFFFF via 65535 words (or a force) and deliver one more word → `word_cnt`=0.
- Assert `rst` after 2 symbols of a word, release, send 7,7,7,7 → `out_data`=12'hFFF, `out_count`=4; the stale partial word never appears.

Source files
------------

// File: rtl/sig_packer.sv
// sig_packer
//   Receives 3-bit symbols from the producer over a valid/ready link and packs
//   SYMS_PER_WORD consecutive symbols into one output word. The first symbol
//   received is placed in bits [SYM_W-1:0]. An in_last marker closes a partial
//   word early. Each word is presented on a registered valid/ready output, and
//   a wrapping counter records how many words have been delivered.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous, active-high reset
//   in_valid   : symbol present
//   in_ready   : block accepts the symbol this cycle
//   in_sig     : symbol payload
//   in_last    : symbol closes the current word, even if it is partial
//   out_valid  : packed word present
//   out_ready  : downstream accepts the word
//   out_data   : packed word, first-received symbol in the low slot
//   out_count  : number of valid symbols in out_data (1..SYMS_PER_WORD)
//   out_last   : word was closed by in_last
//   word_cnt   : number of completed output handshakes, wraps
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer holds valid and payload stable
// until the transfer. in_ready never depends on in_valid. in_ready does depend
// combinationally on out_ready, so a held word and a new symbol can move in
// the same cycle.
module sig_packer #(
  parameter int SYM_W         = 3,
  parameter int SYMS_PER_WORD = 4,
  parameter int CNT_W         = 16,
  localparam int WORD_W       = SYM_W * SYMS_PER_WORD,
  localparam int CW           = $clog2(SYMS_PER_WORD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SYM_W-1:0]  in_sig,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [CW-1:0]     out_count,
  output logic              out_last,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int FW = $clog2(SYMS_PER_WORD);

  // EMPTY   : no symbols accumulated, no word held
  // FILLING : partial word accumulated, no word held
  // HOLD    : a word is presented on out_*. Input is stalled unless
  //           out_ready is high in the same cycle.
  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_FILLING = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [FW-1:0]     fill_cnt, fill_nxt;
  logic [WORD_W-1:0] acc, acc_nxt, word_nxt;
  logic              accept, complete, out_fire;

  assign out_valid = (state == S_HOLD);
  assign in_ready  = !rst && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign complete  = accept && (in_last || (fill_cnt == FW'(SYMS_PER_WORD - 1)));

  // The accumulator is cleared after every word. Slots at or beyond fill_cnt
  // are therefore already zero. Inserting the current symbol gives a word
  // whose unused upper slots read as 0.
  always_comb begin
    word_nxt = acc;
    for (int i = 0; i < SYMS_PER_WORD; i++) begin
      if (FW'(i) == fill_cnt) begin
        word_nxt[i*SYM_W +: SYM_W] = in_sig;
      end
    end
  end

  always_comb begin
    acc_nxt   = acc;
    fill_nxt  = fill_cnt;
    state_nxt = state;
    if (accept) begin
      if (complete) begin
        acc_nxt  = '0;
        fill_nxt = '0;
      end else begin
        acc_nxt  = word_nxt;
        fill_nxt = fill_cnt + FW'(1);
      end
    end
    if (complete) begin
      // This covers the case where an output handshake and a completing
      // accept happen together: the new word replaces the old one with no
      // bubble.
      state_nxt = S_HOLD;
    end else if (out_valid && !out_ready) begin
      state_nxt = S_HOLD;
    end else if (fill_nxt == '0) begin
      state_nxt = S_EMPTY;
    end else begin
      state_nxt = S_FILLING;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_EMPTY;
      fill_cnt <= '0;
      acc      <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
      acc      <= acc_nxt;
    end
  end

  // The output register loads only on completion. A handshake without a new
  // word just drops out_valid (via state) and leaves the payload as it was.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
      word_cnt  <= '0;
    end else begin
      if (complete) begin
        out_data  <= word_nxt;
        out_count <= CW'(fill_cnt) + CW'(1);
        out_last  <= in_last;
      end
      if (out_fire) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

endmodule
